// File: rtl/idli_uart_m_if.sv
// Core-side slice bus of the idli UART: slice counter, TX write slices and RX read slices.
interface idli_uart_m_if;
   logic [1:0] i_uart_ctr;
   logic       i_uart_wr_en;
   logic [3:0] i_uart_slice;
   logic       o_uart_tx_rdy;
   logic       i_uart_rd_en;
   logic [3:0] o_uart_slice;
   logic       o_uart_rx_vld;
   logic       o_uart_rx_ovf;

   modport master (
      output i_uart_ctr, i_uart_wr_en, i_uart_slice, i_uart_rd_en,
      input  o_uart_tx_rdy, o_uart_slice, o_uart_rx_vld, o_uart_rx_ovf
   );

   modport slave (
      input  i_uart_ctr, i_uart_wr_en, i_uart_slice, i_uart_rd_en,
      output o_uart_tx_rdy, o_uart_slice, o_uart_rx_vld, o_uart_rx_ovf
   );
endinterface

// File: rtl/idli_uart_m.sv
// Slice-serial UART for the idli core: 16-bit words move as four 4-bit slices
// on the core side and as two back-to-back 8N1 frames (low byte first) on the line.
module idli_uart_m #(
   parameter int CLK_DIV = 16
) (
   input  logic         i_uart_gck,
   input  logic         i_uart_rst,
   idli_uart_m_if.slave bus,
   input  logic         i_uart_rx,
   output logic         o_uart_tx
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_t;

   logic [1:0] ctr, ctr_nx;
   assign ctr    = bus.i_uart_ctr;
   assign ctr_nx = ctr + 2'd1;

   logic [15:0] tx_hold;
   logic        tx_full, wr_act, wr_cap, wr_done, tx_load;

   assign wr_cap  = bus.i_uart_wr_en && ((ctr == 2'd0) ? !tx_full : wr_act);
   assign wr_done = bus.i_uart_wr_en && wr_act && (ctr == 2'd3);
   assign bus.o_uart_tx_rdy = ~tx_full;

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         wr_act  <= 1'b0;
         tx_full <= 1'b0;
      end else begin
         if (ctr == 2'd0) wr_act <= bus.i_uart_wr_en && !tx_full;
         else if (ctr == 2'd3 || !bus.i_uart_wr_en) wr_act <= 1'b0;
         if (wr_done) tx_full <= 1'b1;
         else if (tx_load) tx_full <= 1'b0;
      end
   end

   always_ff @(posedge i_uart_gck) begin
      if (wr_cap) tx_hold[{ctr, 2'b00} +: 4] <= bus.i_uart_slice;
   end

   uart_st_t         tx_st, tx_st_nx;
   logic [DIV_W-1:0] tx_div, tx_div_nx;
   logic [2:0]       tx_bit, tx_bit_nx;
   logic             tx_hi, tx_hi_nx, tx_line_nx;
   logic [15:0]      tx_sh, tx_sh_nx;

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         tx_st     <= ST_IDLE;
         tx_div    <= '0;
         tx_bit    <= 3'd0;
         tx_hi     <= 1'b0;
         o_uart_tx <= 1'b1;
      end else begin
         tx_st     <= tx_st_nx;
         tx_div    <= tx_div_nx;
         tx_bit    <= tx_bit_nx;
         tx_hi     <= tx_hi_nx;
         o_uart_tx <= tx_line_nx;
      end
   end

   always_ff @(posedge i_uart_gck) tx_sh <= tx_sh_nx;

   // The shifter always presents the current data bit in [0]; after eight
   // shifts the high byte sits in [7:0] ready for the second frame.
   always_comb begin
      tx_st_nx  = tx_st;
      tx_div_nx = tx_div;
      tx_bit_nx = tx_bit;
      tx_hi_nx  = tx_hi;
      tx_sh_nx  = tx_sh;
      tx_load   = 1'b0;
      case (tx_st)
         ST_IDLE: if (tx_full) begin
            tx_load = 1'b1; tx_sh_nx = tx_hold; tx_hi_nx = 1'b0;
            tx_div_nx = '0; tx_st_nx = ST_START;
         end
         ST_START: if (tx_div == DIV_LAST) begin
            tx_div_nx = '0; tx_bit_nx = 3'd0; tx_st_nx = ST_DATA;
         end else tx_div_nx = tx_div + 1'b1;
         ST_DATA: if (tx_div == DIV_LAST) begin
            tx_div_nx = '0;
            tx_sh_nx  = {1'b0, tx_sh[15:1]};
            if (tx_bit == 3'd7) tx_st_nx = ST_STOP;
            else tx_bit_nx = tx_bit + 3'd1;
         end else tx_div_nx = tx_div + 1'b1;
         ST_STOP: if (tx_div == DIV_LAST) begin
            tx_div_nx = '0;
            if (!tx_hi) begin
               tx_hi_nx = 1'b1; tx_st_nx = ST_START;
            end else if (tx_full) begin
               tx_load = 1'b1; tx_sh_nx = tx_hold; tx_hi_nx = 1'b0; tx_st_nx = ST_START;
            end else tx_st_nx = ST_IDLE;
         end else tx_div_nx = tx_div + 1'b1;
         default: tx_st_nx = ST_IDLE;
      endcase
      tx_line_nx = (tx_st_nx == ST_START) ? 1'b0 :
                   (tx_st_nx == ST_DATA)  ? tx_sh_nx[0] : 1'b1;
   end

   uart_st_t         rx_st, rx_st_nx;
   logic [DIV_W-1:0] rx_div, rx_div_nx;
   logic [2:0]       rx_bit, rx_bit_nx;
   logic             rx_hi, rx_hi_nx, rx_shift, rx_lo_ld, rx_done;
   logic             rx_s1, rx_s2, rx_s3;
   logic [7:0]       rx_sh, rx_lo;

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         {rx_s1, rx_s2, rx_s3} <= 3'b111;
         rx_st  <= ST_IDLE;
         rx_div <= '0;
         rx_bit <= 3'd0;
         rx_hi  <= 1'b0;
      end else begin
         {rx_s1, rx_s2, rx_s3} <= {i_uart_rx, rx_s1, rx_s2};
         rx_st  <= rx_st_nx;
         rx_div <= rx_div_nx;
         rx_bit <= rx_bit_nx;
         rx_hi  <= rx_hi_nx;
      end
   end

   always_ff @(posedge i_uart_gck) begin
      if (rx_shift) rx_sh <= {rx_s2, rx_sh[7:1]};
      if (rx_lo_ld) rx_lo <= rx_sh;
   end

   // A bad stop bit also drops a pending low byte so words never straddle an error.
   always_comb begin
      rx_st_nx  = rx_st;
      rx_div_nx = rx_div;
      rx_bit_nx = rx_bit;
      rx_hi_nx  = rx_hi;
      rx_shift  = 1'b0;
      rx_lo_ld  = 1'b0;
      rx_done   = 1'b0;
      case (rx_st)
         ST_IDLE: if (rx_s3 && !rx_s2) begin
            rx_div_nx = '0; rx_st_nx = ST_START;
         end
         ST_START: if (rx_div == DIV_HALF) begin
            rx_div_nx = '0; rx_bit_nx = 3'd0;
            rx_st_nx  = rx_s2 ? ST_IDLE : ST_DATA;
         end else rx_div_nx = rx_div + 1'b1;
         ST_DATA: if (rx_div == DIV_LAST) begin
            rx_div_nx = '0; rx_shift = 1'b1;
            if (rx_bit == 3'd7) rx_st_nx = ST_STOP;
            else rx_bit_nx = rx_bit + 3'd1;
         end else rx_div_nx = rx_div + 1'b1;
         ST_STOP: if (rx_div == DIV_LAST) begin
            rx_div_nx = '0; rx_st_nx = ST_IDLE;
            if (!rx_s2) rx_hi_nx = 1'b0;
            else if (!rx_hi) begin
               rx_hi_nx = 1'b1; rx_lo_ld = 1'b1;
            end else begin
               rx_hi_nx = 1'b0; rx_done = 1'b1;
            end
         end else rx_div_nx = rx_div + 1'b1;
         default: rx_st_nx = ST_IDLE;
      endcase
   end

   logic [15:0] rx_hold, rx_hold_nx;
   logic        rx_vld, rx_vld_nx, rx_ovf, rd_done, rx_take;
   logic [3:0]  rd_slice_q;

   assign rd_done    = bus.i_uart_rd_en && rx_vld && (ctr == 2'd3);
   assign rx_take    = rx_done && (!rx_vld || rd_done);
   assign rx_vld_nx  = rx_take ? 1'b1 : (rd_done ? 1'b0 : rx_vld);
   assign rx_hold_nx = rx_take ? {rx_sh, rx_lo} : rx_hold;

   always_ff @(posedge i_uart_gck) rx_hold <= rx_hold_nx;

   // The slice counter is free-running, so the slice for the next ctr value
   // is registered one cycle early and lines up with ctr on the output.
   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         rx_vld     <= 1'b0;
         rx_ovf     <= 1'b0;
         rd_slice_q <= 4'd0;
      end else begin
         rx_vld     <= rx_vld_nx;
         if (rd_done) rx_ovf <= 1'b0;
         else if (rx_done && rx_vld) rx_ovf <= 1'b1;
         rd_slice_q <= rx_vld_nx ? rx_hold_nx[{ctr_nx, 2'b00} +: 4] : 4'd0;
      end
   end

   assign bus.o_uart_rx_vld = rx_vld;
   assign bus.o_uart_rx_ovf = rx_ovf;
   assign bus.o_uart_slice  = rd_slice_q;

endmodule

// File: doc/idli_uart_m.md
# idli_uart_m

Slice-serial UART for the idli core, replacing the tied-off `o_top_uart_tx` / `i_top_uart_rx` pins in the top level. It sits beside the SQI memory stage on the same 4-cycle slice counter (`ctr_t`). On the core side it moves 16-bit `data_t` words as four 4-bit slices, least significant slice first. On the line side it moves each word as two 8N1 frames, low byte first.

## Interface
Parameters:
- `CLK_DIV`, default 16: clock cycles per UART bit period. Must be even and ≥ 4.

Ports:
- `i_uart_gck`  in  1  core clock; the single clock of the block.
- `i_uart_rst`  in  1  reset, asynchronous, active-high.
- `i_uart_ctr`  in  2  slice counter (`ctr_t`); slice n of a word transfers when ctr == n.
- `i_uart_wr_en`  in  1  TX word write, held high for ctr 0..3.
- `i_uart_slice`  in  4  TX write data slice.
- `o_uart_tx_rdy`  out  1  TX holding register empty; a write may begin at the next ctr == 0.
- `i_uart_rd_en`  in  1  RX word read, held high for ctr 0..3.
- `o_uart_slice`  out  4  RX read data slice for the current ctr.
- `o_uart_rx_vld`  out  1  RX holding register full.
- `o_uart_rx_ovf`  out  1  sticky overrun flag.
- `i_uart_rx`  in  1  serial line in; asynchronous to the clock.
- `o_uart_tx`  out  1  serial line out; idles high.

## Operation
TX path:
- Write acceptance: a write is accepted only if `wr_en`=1 and `tx_rdy`=1 at ctr==0. Slice n is captured into holding bits [4n+3:4n].
- Write completion: the write completes at ctr==3, which sets holding full.
- Ignored writes: `wr_en` with `tx_rdy`=0 at ctr==0 is ignored for the whole word. Dropping `wr_en` mid-word abandons the write and leaves holding empty.
- Engine states: IDLE, START, DATA(0..7), STOP, then the same sequence for the second byte.
- Frame format: start bit 0, eight data bits LSB first, stop bit 1. Each bit lasts `CLK_DIV` cycles.
- Load: in IDLE with holding full, the engine loads the shifter and holding empties.
- Byte order: the low byte is sent first and the high byte follows with no idle gap. One word takes 20 bit periods.

RX path:
- Synchronizer: `i_uart_rx` passes through a 2-flop synchronizer.
- Start detection: a falling edge in IDLE starts a frame. The start bit is re-sampled at `CLK_DIV/2` cycles; if it is high, the engine aborts to IDLE.
- Data sampling: data bits are sampled at bit centres, every `CLK_DIV` cycles, LSB first.
- Stop-bit check: the stop bit must be 1. A framing error discards the current byte and any partial word, and returns the engine to IDLE.
- Word assembly: the first good byte fills bits [7:0] and the second fills bits [15:8]. Any idle gap between the two bytes is allowed.
- Word delivery: a completed word goes into holding if holding is empty, setting `rx_vld`. If holding is full, the word is dropped and `rx_ovf` is set.
- Reads: a read with `rd_en`=1 at ctr 0..3 and `rx_vld`=1 drives holding slice[ctr] on `o_uart_slice`. At ctr==3 holding empties and `rx_ovf` clears.
- Read with nothing held: when `rx_vld`=0, `o_uart_slice` is 0 and a read has no effect.

## Timing
- Reset values: `o_uart_tx`=1, `tx_rdy`=1, `rx_vld`=0, `rx_ovf`=0, `o_uart_slice`=0. All engines go to IDLE, holding registers empty, bit and divider counters are 0.
- Reset mid-frame: `o_uart_tx` goes high asynchronously and partial TX/RX frames are lost.
- Write acceptance to `tx_rdy`: `tx_rdy` falls in the cycle after the accepting ctr==3 edge.
- Write to line: if the engine is IDLE, the start bit appears on `o_uart_tx` one cycle after that and `tx_rdy` rises in the same cycle. Holding plus shifter form a double buffer.
- Back-to-back TX words: a word written during transmission starts its start bit in the cycle after the previous word's second stop bit ends. There is no idle gap.
- RX delivery: `rx_vld` rises in the cycle after the second byte's stop bit is sampled good.
- `o_uart_slice` is registered: slice[ctr] is valid during the cycle in which ctr equals n while `rd_en` is held.
- Read and delivery in the same cycle: if a read completes (ctr==3) in the same cycle a new word completes, the new word is accepted, `rx_vld` stays 1 and `rx_ovf` is not set.
- Overrun, delivery and read in the same cycle: if overrun occurs in the cycle a read completes, clearing takes priority, so `rx_ovf`=0 and the new word is held.
- Idle RX: the RX engine ignores a line held low in IDLE until it sees a high-to-low transition.

## Test plan
- Reset, then write 0xA55A with `CLK_DIV`=4 → `tx_rdy` falls then rises one cycle later. The line shows 0,0x5A LSB-first,1,0,0xA5,1 at 4 cycles per bit, then stays high.
- Two back-to-back writes, 0x1234 then 0xFFFF → 40 contiguous bit periods with no idle gap. The second write is accepted only after `tx_rdy` reasserts.
- Drive RX frames for 0x34 then 0x12 → `rx_vld`=1. A read returns slices 4,3,2,1 on ctr 0..3, then `rx_vld`=0.
- Deliver two RX words without reading → the first word is kept, `rx_ovf`=1. The next read returns the first word and clears `rx_ovf`.
- RX frame with the stop bit at 0, then a good pair 0xCD,0xAB → the bad byte is discarded and the read returns 0xABCD.
- Assert `i_uart_rst` mid-TX byte → `o_uart_tx`=1 immediately and `tx_rdy`=1. A new write after reset transmits cleanly.
